// File: rtl/spram_ctrl.sv
// spram_ctrl: single-port RAM controller with a registered read path (RD_LATENCY 1 or 2).
// Define SPRAM_CLEAR_EN to compile in the post-reset zero-fill sweep (CLEAR -> READY FSM).
module spram_ctrl #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 2048,
  parameter int BUS_ADDR_WIDTH = 13,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic [DATA_WIDTH-1:0]     dout,
  input  logic                      csn,
  input  logic                      wen,
  input  logic                      oen,
  output logic                      rvalid,
  output logic                      busy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  bus_we;
  logic                  rd_acc;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  pipe_v;
  logic [DATA_WIDTH-1:0] pipe_d;
  logic                  unused_ok;

  // Upper address bits are deliberately dropped so the RAM mirrors every DEPTH words.
  assign unused_ok = ^bus_addr;
  assign idx       = bus_addr[ADDR_WIDTH-1:0];
  assign bus_we    = !csn && !wen && !busy;
  assign rd_acc    = !csn && wen && !oen && !busy;

`ifdef SPRAM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  assign we    = clr_we || bus_we;
  assign waddr = clr_we ? clr_idx : idx;
  assign wdata = clr_we ? '0 : din;

  // Memory has no reset; gating on rst keeps reset from touching contents.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= 1'b0;
      pipe_d <= '0;
      rvalid <= 1'b0;
      dout   <= '0;
    end else begin
      pipe_v <= rd_acc;
      if (rd_acc) pipe_d <= mem[idx];
      if (RD_LATENCY == 1) begin
        rvalid <= rd_acc;
        if (rd_acc) dout <= mem[idx];
      end else begin
        rvalid <= pipe_v;
        if (pipe_v) dout <= pipe_d;
      end
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: table vectors plus randomized traffic against an array/queue reference model,
// run on a latency-1 and a latency-2 instance side by side. Honours SPRAM_CLEAR_EN if defined.
module tb_spram_ctrl;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;
  localparam int BAW   = 13;
`ifdef SPRAM_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [BAW-1:0] bus_addr = '0;
  logic [DW-1:0]  din = '0;
  logic           csn = 1'b1, wen = 1'b1, oen = 1'b1;
  logic [DW-1:0]  dout1, dout2;
  logic           rvalid1, rvalid2, busy1, busy2;

  always #5 clk = ~clk;

  spram_ctrl #(.RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .din(din), .dout(dout1),
    .csn(csn), .wen(wen), .oen(oen), .rvalid(rvalid1), .busy(busy1)
  );

  spram_ctrl #(.RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .din(din), .dout(dout2),
    .csn(csn), .wen(wen), .oen(oen), .rvalid(rvalid2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word array with "known" flags, plus one pending slot for the latency-2 path.
  logic [DW-1:0] m [DEPTH];
  bit            known [DEPTH];
  bit            exp_rv1, exp_rv2, exp_k1, exp_k2, pend_v, pend_k;
  logic [DW-1:0] exp_d1, exp_d2, pend_d;
  int            clr_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_rv1 = 0; exp_rv2 = 0; exp_d1 = '0; exp_d2 = '0;
    exp_k1 = 1;  exp_k2 = 1;  pend_v = 0;
    clr_left = CLEAR ? DEPTH : 0;
  endtask

  task automatic model_step();
    logic [AW-1:0] i;
    logic [DW-1:0] rd;
    bit            rk, bsy, acc_w, acc_r;
    if (rst) begin
      model_reset();
      return;
    end
    i     = bus_addr[AW-1:0];
    bsy   = clr_left > 0;
    acc_w = !csn && !wen && !bsy;
    acc_r = !csn && wen && !oen && !bsy;
    rd    = m[i];
    rk    = known[i];
    exp_rv2 = pend_v;
    if (pend_v) begin exp_d2 = pend_d; exp_k2 = pend_k; end
    pend_v = acc_r; pend_d = rd; pend_k = rk;
    exp_rv1 = acc_r;
    if (acc_r) begin exp_d1 = rd; exp_k1 = rk; end
    if (acc_w) begin m[i] = din; known[i] = 1; end
    if (bsy) begin
      clr_left--;
      if (clr_left == 0)
        for (int k = 0; k < DEPTH; k++) begin m[k] = '0; known[k] = 1; end
    end
  endtask

  task automatic check_outputs();
    check("rvalid_lat1", rvalid1, exp_rv1);
    check("rvalid_lat2", rvalid2, exp_rv2);
    check("busy_lat1", busy1, clr_left > 0);
    check("busy_lat2", busy2, clr_left > 0);
    if (exp_k1) check("dout_lat1", dout1, exp_d1);
    if (exp_k2) check("dout_lat2", dout2, exp_d2);
  endtask

  task automatic cycle(input logic c, input logic w, input logic o,
                       input logic [BAW-1:0] a, input logic [DW-1:0] d);
    csn = c; wen = w; oen = o; bus_addr = a; din = d;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic rand_cycle();
    logic [AW-1:0]  pool [8];
    logic [BAW-1:0] a;
    pool = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h004, 11'h123, 11'h7FF, 11'd1999};
    a = BAW'($urandom);
    if ($urandom_range(0, 9) < 8) a[AW-1:0] = pool[$urandom_range(0, 7)];
    cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          a, DW'($urandom));
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
  endtask

  task automatic reset_and_wait();
    assert_reset();
    cycle(1, 1, 1, '0, '0);
    rst = 1'b0;
    for (int n = 0; n < DEPTH + 4 && clr_left > 0; n++) cycle(1, 1, 1, '0, '0);
  endtask

  typedef struct {
    logic           c, w, o;
    logic [BAW-1:0] a;
    logic [DW-1:0]  d;
    logic           rv;
    logic [DW-1:0]  q;
  } vec_t;

  vec_t tv [14];
  int   nb;
  logic prev_rv;
  logic [DW-1:0] prev_q;

  initial begin
    tv[0]  = '{1'b0, 1'b0, 1'b1, 13'h0123, 8'hA5, 1'b0, 8'h00};  // write
    tv[1]  = '{1'b0, 1'b1, 1'b0, 13'h0923, 8'h00, 1'b1, 8'hA5};  // mirror read, next cycle
    tv[2]  = '{1'b0, 1'b0, 1'b1, 13'h0001, 8'h11, 1'b0, 8'hA5};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 13'h0002, 8'h22, 1'b0, 8'hA5};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 13'h0003, 8'h33, 1'b0, 8'hA5};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 13'h0001, 8'h00, 1'b1, 8'h11};  // back-to-back reads
    tv[6]  = '{1'b0, 1'b1, 1'b0, 13'h0002, 8'h00, 1'b1, 8'h22};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 13'h0003, 8'h00, 1'b1, 8'h33};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 13'h0004, 8'h5A, 1'b0, 8'h33};  // write wins over oen=0
    tv[9]  = '{1'b0, 1'b1, 1'b0, 13'h1004, 8'h00, 1'b1, 8'h5A};
    tv[10] = '{1'b1, 1'b1, 1'b0, 13'h0003, 8'h00, 1'b0, 8'h5A};  // idle
    tv[11] = '{1'b0, 1'b1, 1'b1, 13'h0003, 8'h00, 1'b0, 8'h5A};  // idle
    tv[12] = '{1'b1, 1'b0, 1'b1, 13'h0123, 8'hFF, 1'b0, 8'h5A};  // deselected write
    tv[13] = '{1'b0, 1'b1, 1'b0, 13'h0123, 8'h00, 1'b1, 8'hA5};

    // Power-up reset, then sweep (busy counted per pre-edge sample) with random traffic.
    for (int k = 0; k < DEPTH; k++) known[k] = 0;
    assert_reset();
    cycle(1, 1, 1, '0, '0);
    cycle(1, 1, 1, '0, '0);
    rst = 1'b0;
    nb = 0;
    for (int n = 0; n < DEPTH + 16; n++) begin
      if (busy1) nb++;
      rand_cycle();
    end
    check("busy_cycles_after_reset", nb, CLEAR ? DEPTH : 0);
    cycle(0, 1, 0, 13'h07FF, '0);

    // Table vectors; the latency-2 instance must show the previous row's expectation.
    reset_and_wait();
    prev_rv = 1'b0;
    prev_q  = '0;
    for (int i = 0; i < 14; i++) begin
      cycle(tv[i].c, tv[i].w, tv[i].o, tv[i].a, tv[i].d);
      check($sformatf("tbl%0d_rvalid1", i), rvalid1, tv[i].rv);
      check($sformatf("tbl%0d_dout1", i), dout1, tv[i].q);
      check($sformatf("tbl%0d_rvalid2", i), rvalid2, prev_rv);
      check($sformatf("tbl%0d_dout2", i), dout2, prev_q);
      prev_rv = tv[i].rv;
      prev_q  = tv[i].q;
    end

    for (int n = 0; n < 3000; n++) rand_cycle();

    // Reset with a latency-2 read in flight: it must be dropped.
    cycle(0, 1, 0, 13'h0001, '0);
    assert_reset();
    cycle(0, 1, 0, 13'h0002, '0);
    check("inflight_dropped", rvalid2, 1'b0);
    rst = 1'b0;
    for (int n = 0; n < DEPTH + 4 && clr_left > 0; n++) rand_cycle();
    for (int n = 0; n < 200; n++) rand_cycle();

`ifdef SPRAM_CLEAR_EN
    // Reset pulsed mid-sweep at index 1000: sweep restarts and covers the full range.
    cycle(0, 0, 1, 13'h0000, 8'h77);
    cycle(0, 0, 1, 13'd1999, 8'h99);
    assert_reset();
    cycle(1, 1, 1, '0, '0);
    rst = 1'b0;
    for (int n = 0; n < 1000; n++) cycle(1, 1, 1, '0, '0);
    assert_reset();
    cycle(1, 1, 1, '0, '0);
    rst = 1'b0;
    nb = 0;
    for (int n = 0; n < DEPTH + 16; n++) begin
      if (busy1) nb++;
      cycle(1, 1, 1, '0, '0);
    end
    check("busy_cycles_restart", nb, DEPTH);
    cycle(0, 1, 0, 13'h0000, '0);
    check("restart_idx0", dout1, 8'h00);
    cycle(0, 1, 0, 13'd1999, '0);
    check("restart_idx1999", dout1, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
